// File: rtl/pulse_stretch_fsm_if.sv
// pulse_stretch_fsm_if
// Groups the event/config inputs and the stretched-level outputs of
// pulse_stretch_fsm into a single bundle.
//   pulse_in  : event strobe, one event per high cycle
//   hold_len  : high-window length in cycles (0 behaves as 1)
//   gap_len   : minimum low gap after each window (0 behaves as 1)
//   retrig_en : 1 = pulse during a window reloads it, 0 = pulse is queued
//   level_out : stretched level, high exactly while a window is active
//   remain    : remaining high cycles including the current one, 0 otherwise
//   pending   : queued events not yet served
//   drop      : one-cycle flag, an event was lost to pending saturation
// Modports: master drives the events/config, slave is the stretcher.
interface pulse_stretch_fsm_if #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
);
  logic              pulse_in;
  logic [CNT_W-1:0]  hold_len;
  logic [CNT_W-1:0]  gap_len;
  logic              retrig_en;
  logic              level_out;
  logic [CNT_W-1:0]  remain;
  logic [PEND_W-1:0] pending;
  logic              drop;

  modport master (
    output pulse_in, hold_len, gap_len, retrig_en,
    input  level_out, remain, pending, drop
  );

  modport slave (
    input  pulse_in, hold_len, gap_len, retrig_en,
    output level_out, remain, pending, drop
  );
endinterface

// File: rtl/pulse_stretch_fsm.sv
// pulse_stretch_fsm
// Turns single-cycle event pulses into level windows: each accepted event
// gives a high window of max(hold_len,1) cycles followed by a low gap of at
// least max(gap_len,1) cycles. Events during a window either reload it
// (retrig_en=1) or are queued in a saturating counter and replayed later.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : pulse_stretch_fsm_if slave modport (events, config, outputs)
// All outputs are registers; there is no combinational path from pulse_in.
module pulse_stretch_fsm #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
) (
  input logic                clk,
  input logic                reset,
  pulse_stretch_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1'b1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [PEND_W-1:0] pending_r, pending_s;
  logic              drop_r, drop_s;
  logic              level_r;
  logic [CNT_W-1:0]  remain_r;
  logic              inc_s, dec_s;
  logic [CNT_W-1:0]  hold_eff_s, gap_eff_s;

  // Zero-length configurations behave as one cycle.
  always_comb begin
    hold_eff_s = bus.hold_len;
    gap_eff_s  = bus.gap_len;
    if (bus.hold_len == CNT_ZERO) begin
      hold_eff_s = CNT_ONE;
    end else begin
      hold_eff_s = bus.hold_len;
    end
    if (bus.gap_len == CNT_ZERO) begin
      gap_eff_s = CNT_ONE;
    end else begin
      gap_eff_s = bus.gap_len;
    end
  end

  // Next-state, window counter and queue increment/decrement decisions.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    inc_s   = 1'b0;
    dec_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.pulse_in) begin
          state_s = HOLD;
          cnt_s   = hold_eff_s;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      HOLD: begin
        if (bus.pulse_in && bus.retrig_en) begin
          cnt_s = hold_eff_s;
        end else begin
          inc_s = bus.pulse_in;
          if (cnt_r == CNT_ONE) begin
            state_s = GAP;
            cnt_s   = gap_eff_s;
          end else begin
            cnt_s   = cnt_r - CNT_ONE;
          end
        end
      end
      GAP: begin
        // Pulses in the gap are always queued; retriggering cannot shorten it.
        inc_s = bus.pulse_in;
        if (cnt_r > CNT_ONE) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if ((pending_r != '0) || bus.pulse_in) begin
          state_s = HOLD;
          cnt_s   = hold_eff_s;
          dec_s   = 1'b1;
        end else begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Saturating pending counter; a same-edge inc and dec cancel out.
  always_comb begin
    pending_s = pending_r;
    drop_s    = 1'b0;
    if (inc_s && !dec_s) begin
      if (pending_r == PEND_MAX) begin
        drop_s = 1'b1;
      end else begin
        pending_s = pending_r + PEND_ONE;
      end
    end else if (dec_s && !inc_s) begin
      pending_s = pending_r - PEND_ONE;
    end else begin
      pending_s = pending_r;
    end
  end

  // State, counter and registered outputs (outputs derived from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      pending_r <= '0;
      drop_r    <= 1'b0;
      level_r   <= 1'b0;
      remain_r  <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pending_r <= pending_s;
      drop_r    <= drop_s;
      level_r   <= (state_s == HOLD);
      remain_r  <= (state_s == HOLD) ? cnt_s : CNT_ZERO;
    end
  end

  assign bus.level_out = level_r;
  assign bus.remain    = remain_r;
  assign bus.pending   = pending_r;
  assign bus.drop      = drop_r;

endmodule

// File: tb/tb_pulse_stretch_fsm.sv
// tb_pulse_stretch_fsm
// Directed bench for pulse_stretch_fsm (CNT_W=8, PEND_W=2). Inputs change
// 1ns after each rising edge; outputs are checked at that same point,
// i.e. they reflect the edge just taken.
module tb_pulse_stretch_fsm;
  localparam int CNT_W  = 8;
  localparam int PEND_W = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   rises;
  logic prev_lvl;

  pulse_stretch_fsm_if #(.CNT_W(CNT_W), .PEND_W(PEND_W)) bus ();

  pulse_stretch_fsm #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic el, input logic [7:0] er,
                     input logic [1:0] ep, input logic ed);
    cmp({tag, ".level"},   32'(bus.level_out), 32'(el));
    cmp({tag, ".remain"},  32'(bus.remain),    32'(er));
    cmp({tag, ".pending"}, 32'(bus.pending),   32'(ep));
    cmp({tag, ".drop"},    32'(bus.drop),      32'(ed));
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.pulse_in  = 1'b0;
    bus.hold_len  = 8'd0;
    bus.gap_len   = 8'd0;
    bus.retrig_en = 1'b0;
    tick();
    tick();
    chk("rst", 1'b0, 8'd0, 2'd0, 1'b0);
    reset = 1'b0;

    // Single event, L=3 G=2; hold_len change after load must not matter.
    bus.hold_len = 8'd3; bus.gap_len = 8'd2; bus.pulse_in = 1'b1;
    tick(); chk("single.e1", 1'b1, 8'd3, 2'd0, 1'b0);
    bus.pulse_in = 1'b0; bus.hold_len = 8'd7;
    tick(); chk("single.e2", 1'b1, 8'd2, 2'd0, 1'b0);
    tick(); chk("single.e3", 1'b1, 8'd1, 2'd0, 1'b0);
    tick(); chk("single.e4", 1'b0, 8'd0, 2'd0, 1'b0);
    tick(); chk("single.e5", 1'b0, 8'd0, 2'd0, 1'b0);
    tick(); chk("single.e6", 1'b0, 8'd0, 2'd0, 1'b0);

    // Zero lengths behave as 1; second pulse queued and replayed.
    bus.hold_len = 8'd0; bus.gap_len = 8'd0; bus.pulse_in = 1'b1;
    tick(); chk("zero.e1", 1'b1, 8'd1, 2'd0, 1'b0);
    tick(); chk("zero.e2", 1'b0, 8'd0, 2'd1, 1'b0);
    bus.pulse_in = 1'b0;
    tick(); chk("zero.e3", 1'b1, 8'd1, 2'd0, 1'b0);
    tick(); chk("zero.e4", 1'b0, 8'd0, 2'd0, 1'b0);
    tick(); chk("zero.e5", 1'b0, 8'd0, 2'd0, 1'b0);

    // Retrigger, L=4 G=1: pulses at edges 1 and 3, falls at edge 7.
    bus.retrig_en = 1'b1; bus.hold_len = 8'd4; bus.gap_len = 8'd1; bus.pulse_in = 1'b1;
    tick(); chk("retrig.e1", 1'b1, 8'd4, 2'd0, 1'b0);
    bus.pulse_in = 1'b0;
    tick(); chk("retrig.e2", 1'b1, 8'd3, 2'd0, 1'b0);
    bus.pulse_in = 1'b1;
    tick(); chk("retrig.e3", 1'b1, 8'd4, 2'd0, 1'b0);
    bus.pulse_in = 1'b0;
    tick(); chk("retrig.e4", 1'b1, 8'd3, 2'd0, 1'b0);
    tick(); chk("retrig.e5", 1'b1, 8'd2, 2'd0, 1'b0);
    tick(); chk("retrig.e6", 1'b1, 8'd1, 2'd0, 1'b0);
    tick(); chk("retrig.e7", 1'b0, 8'd0, 2'd0, 1'b0);
    tick(); chk("retrig.e8", 1'b0, 8'd0, 2'd0, 1'b0);

    // Queueing, L=2 G=1: pulses at edges 1,2,3 -> windows at 1,4,7.
    bus.retrig_en = 1'b0; bus.hold_len = 8'd2; bus.gap_len = 8'd1; bus.pulse_in = 1'b1;
    tick(); chk("queue.e1", 1'b1, 8'd2, 2'd0, 1'b0);
    tick(); chk("queue.e2", 1'b1, 8'd1, 2'd1, 1'b0);
    tick(); chk("queue.e3", 1'b0, 8'd0, 2'd2, 1'b0);
    bus.pulse_in = 1'b0;
    tick(); chk("queue.e4", 1'b1, 8'd2, 2'd1, 1'b0);
    tick(); chk("queue.e5", 1'b1, 8'd1, 2'd1, 1'b0);
    tick(); chk("queue.e6", 1'b0, 8'd0, 2'd1, 1'b0);
    tick(); chk("queue.e7", 1'b1, 8'd2, 2'd0, 1'b0);
    tick(); chk("queue.e8", 1'b1, 8'd1, 2'd0, 1'b0);
    tick(); chk("queue.e9", 1'b0, 8'd0, 2'd0, 1'b0);
    tick(); chk("queue.e10", 1'b0, 8'd0, 2'd0, 1'b0);

    // Saturation, L=10 G=1, pulse high 6 cycles: 2 drops, 4 windows.
    bus.hold_len = 8'd10; bus.gap_len = 8'd1; bus.pulse_in = 1'b1;
    tick(); chk("sat.e1", 1'b1, 8'd10, 2'd0, 1'b0);
    tick(); chk("sat.e2", 1'b1, 8'd9,  2'd1, 1'b0);
    tick(); chk("sat.e3", 1'b1, 8'd8,  2'd2, 1'b0);
    tick(); chk("sat.e4", 1'b1, 8'd7,  2'd3, 1'b0);
    tick(); chk("sat.e5", 1'b1, 8'd6,  2'd3, 1'b1);
    tick(); chk("sat.e6", 1'b1, 8'd5,  2'd3, 1'b1);
    bus.pulse_in = 1'b0;
    tick(); chk("sat.e7", 1'b1, 8'd4,  2'd3, 1'b0);
    rises    = 1;
    prev_lvl = bus.level_out;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.level_out && !prev_lvl) rises++;
      prev_lvl = bus.level_out;
    end
    cmp("sat.windows", 32'(rises), 32'd4);
    chk("sat.end", 1'b0, 8'd0, 2'd0, 1'b0);

    // Reset mid-window with a queued event and a same-edge pulse.
    bus.hold_len = 8'd8; bus.gap_len = 8'd1; bus.pulse_in = 1'b1;
    tick(); chk("rstmid.e1", 1'b1, 8'd8, 2'd0, 1'b0);
    tick(); chk("rstmid.e2", 1'b1, 8'd7, 2'd1, 1'b0);
    bus.pulse_in = 1'b0;
    tick(); chk("rstmid.e3", 1'b1, 8'd6, 2'd1, 1'b0);
    reset = 1'b1; bus.pulse_in = 1'b1;
    tick(); chk("rstmid.e4", 1'b0, 8'd0, 2'd0, 1'b0);
    reset = 1'b0; bus.pulse_in = 1'b0;
    tick(); chk("rstmid.e5", 1'b0, 8'd0, 2'd0, 1'b0);
    tick();
    tick(); chk("rstmid.e7", 1'b0, 8'd0, 2'd0, 1'b0);

    // Fresh pulse after reset is accepted with 1-cycle latency.
    bus.pulse_in = 1'b1;
    tick(); chk("post.e1", 1'b1, 8'd8, 2'd0, 1'b0);
    bus.pulse_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_stretch_fsm.md
# pulse_stretch_fsm

Converts single-cycle event pulses back into clean level windows: each accepted pulse on `pulse_in` produces a `level_out` high window of programmable length, followed by a programmable minimum low gap. Events arriving while a window is active are either merged by retriggering or queued in a saturating pending counter and replayed as separate windows. It is the consumer-side companion of the level-to-pulse edge detectors in the control path, restoring level semantics for downstream enables and handshake strobes.

## Interface
- `CNT_W`, 8, width of the hold/gap length inputs and the internal window counter
- `PEND_W`, 4, width of the pending-event counter; saturates at 2^PEND_W-1

- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high; clock `clk`
- `pulse_in`  in  1  event strobe, sampled every rising edge; consecutive high cycles count as separate events
- `hold_len`  in  CNT_W  high-window length in cycles; 0 is treated as 1
- `gap_len`  in  CNT_W  minimum low gap after each window, in cycles; 0 is treated as 1
- `retrig_en`  in  1  1: a pulse during HOLD reloads the window; 0: the pulse is queued
- `level_out`  out  1  registered stretched level; high exactly while in HOLD
- `remain`  out  CNT_W  remaining HOLD cycles including the current one; 0 outside HOLD
- `pending`  out  PEND_W  number of queued events not yet served
- `drop`  out  1  one-cycle registered flag; an event was lost to saturation

## Operation
- Definitions: L = max(hold_len,1) and G = max(gap_len,1), both sampled at the edge that loads the counter. Later changes to `hold_len` or `gap_len` do not affect a window already loaded.
- States: IDLE, HOLD, GAP. `level_out` = (state == HOLD). This is a Moore output with no combinational path from `pulse_in`.
- IDLE:
  - `pulse_in` = 1 -> HOLD, cnt = L.
  - `pending` is always 0 in IDLE.
- HOLD, on each edge:
  - If `pulse_in` && `retrig_en`: cnt = L; stay in HOLD; `pending` unchanged.
  - Else if `pulse_in` && !`retrig_en`: the event is queued (`pending`+1). Counting proceeds as below.
  - If cnt == 1 and no retrigger -> GAP, cnt = G. Otherwise cnt decrements.
- GAP, on each edge:
  - `pulse_in` = 1 always queues the event, regardless of `retrig_en`.
  - If cnt > 1: cnt decrements.
  - If cnt == 1 and (`pending` > 0 or `pulse_in`): go to HOLD with cnt = L, consuming one event.
  - If cnt == 1 and no event is available: go to IDLE.
- Pending arithmetic per edge: pending_next = pending + inc − dec.
  - inc = queued pulse this edge; dec = event consumed on the GAP->HOLD transition.
  - A pulse arriving on the same edge it would be consumed gives a net change of 0.
  - If pending = 2^PEND_W−1 and inc && !dec: the event is discarded, `pending` holds, and `drop` = 1 on the next cycle.
- `remain` = cnt in HOLD, else 0.
- Reset (any state, including mid-window):
  - state IDLE, cnt 0.
  - `level_out` 0, `remain` 0, `pending` 0, `drop` 0.
  - Reset dominates `pulse_in` on the same edge; that pulse is lost and no `drop` is raised.

## Timing
- Accept latency: a pulse sampled at edge k raises `level_out` after edge k (1 cycle).
- Window: `level_out` is high for exactly L cycles (edges k .. k+L−1) and falls at edge k+L.
- The earliest next window starts at edge k+L+G. `level_out` is never high for two windows without at least G low cycles between them.
- Retrigger at edge j during HOLD: `level_out` stays high through edge j+L−1 and falls at edge j+L.
- Queued back-to-back events: windows start at k, k+(L+G), k+2(L+G), and so on.
- `drop` asserts for one cycle, following the edge that discarded the event.

## Test plan
- Single event: hold_len=3, gap_len=2, pulse at edge 1 -> `level_out` high after edges 1..3, low at 4; `remain` reads 3,2,1; state returns to IDLE at edge 6.
- Zero lengths: hold_len=0, gap_len=0, pulses at edges 1 and 2 -> window 1 cycle high at edge 1, low at edge 2, second window high at edge 3; `pending` reads 1 after edge 2 and 0 after edge 3.
- Retrigger: retrig_en=1, hold_len=4, pulses at edges 1 and 3 -> `level_out` continuously high edges 1..6, falls at edge 7; `pending` stays 0.
- Queueing: retrig_en=0, hold_len=2, gap_len=1, pulses at edges 1,2,3 -> windows start at edges 1,4,7, each 2 cycles high with 1 cycle low between; `pending` peaks at 2.
- Saturation: PEND_W=2, retrig_en=0, hold_len=10, pulse held high 6 cycles -> `pending` saturates at 3, `drop` pulses for the 2 excess events, and exactly 4 windows are produced in total.
- Reset mid-window: hold_len=8, pulse at edge 1, reset at edge 4 with pulse_in=1 -> after edge 4 all outputs are 0 and state is IDLE; no window follows without a new pulse.
